// File: rtl/mdu_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle; sign fix-up in FIX; done pulses in DONE.
module mdu_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sel_rem_q, sel_rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             is_signed;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Request decode, evaluated on the live inputs in IDLE
    always_comb begin
        is_signed   = ~op[0];
        div_zero    = (in2 == '0);
        overflow    = is_signed && (in1 == MIN_NEG) && (in2 == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? in1 : '1;
        end else if (overflow) begin
            special_res = op[1] ? '0 : in1;
        end
    end

    // Trial subtraction is one bit wider so the top divisor bit never overflows
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        quo_fix = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        sel_rem_d = sel_rem_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    sel_rem_d = op[1];
                    q_neg_d   = is_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
                    r_neg_d   = is_signed && in1[WIDTH-1];
                    if (div_zero || overflow) begin
                        result_d = special_res;
                        state_d  = ST_DONE;
                    end else begin
                        quo_d   = (is_signed && in1[WIDTH-1]) ? (~in1 + 1'b1) : in1;
                        dvs_d   = (is_signed && in2[WIDTH-1]) ? (~in2 + 1'b1) : in2;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = sel_rem_q ? rem_fix : quo_fix;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                // Result is already committed, so kill has no effect here
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            sel_rem_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            sel_rem_q <= sel_rem_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule
